// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encoding, per-mode schedule constants,
// key-schedule FSM state codes and the GF(2^8) doubling used for rcon.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } key_len_e;

    // Key-schedule FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_GEN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Per-mode constants: words per key, number of rounds, words to generate
    typedef struct packed {
        logic [3:0] nk;
        logic [3:0] nr;
        logic [5:0] total;
    } mode_cfg_t;

    function automatic mode_cfg_t mode_cfg(input logic [1:0] key_len);
        mode_cfg_t cfg;
        case (key_len)
            2'd1:    cfg = '{nk: 4'd6, nr: 4'd12, total: 6'd52};
            2'd2:    cfg = '{nk: 4'd8, nr: 4'd14, total: 6'd60};
            default: cfg = '{nk: 4'd4, nr: 4'd10, total: 6'd44};
        endcase
        return cfg;
    endfunction

    // Key size in bits for a key_len code (the reserved code maps above 256)
    function automatic int key_bits(input logic [1:0] key_len);
        return 128 + 64 * int'(key_len);
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Request and round-key stream signals between the key-load side, the key
// expander and the round-key consumer.
interface aes_key_schedule_if #(
    parameter int MAX_KEY_BITS = 256
);
    logic                    start;
    logic [1:0]              key_len;
    logic [MAX_KEY_BITS-1:0] key_in;
    logic                    busy;
    logic                    err;
    logic                    rk_valid;
    logic                    rk_ready;
    logic [127:0]            rk_data;
    logic [3:0]              rk_idx;
    logic                    rk_last;
    logic                    done;

    // Requester / consumer side
    modport master (
        output start, key_len, key_in, rk_ready,
        input  busy, err, rk_valid, rk_data, rk_idx, rk_last, done
    );

    // Key expander side
    modport slave (
        input  start, key_len, key_in, rk_ready,
        output busy, err, rk_valid, rk_data, rk_idx, rk_last, done
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Table stored with entry 0 in the MSBs; entry x sits at bit (255-x)*8
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_base;

    // Table lookup: ~in_byte == 255-in_byte selects the byte slot
    always_comb begin
        bit_base = {~in_byte, 3'b000};
        out_byte = SBOX[bit_base +: 8];
    end
endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expander. Produces one schedule word per cycle from a
// sliding window of the last Nk words, packs four words per round key and
// streams round keys over a valid/ready handshake with backpressure.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic               clk,
    input  logic               reset,
    aes_key_schedule_if.slave  ks
);
    localparam int NW = MAX_KEY_BITS / 32;

    logic [1:0]              state_reg;
    logic [MAX_KEY_BITS-1:0] key_reg;
    logic [1:0]              mode_reg;
    logic [5:0]              i_reg;
    logic [2:0]              k_reg;
    logic [7:0]              rcon_reg;
    logic [31:0]             win_reg [NW];
    logic [95:0]             acc_reg;
    logic [127:0]            rk_data_reg;
    logic [3:0]              rk_idx_reg;
    logic                    rk_valid_reg;
    logic                    rk_last_reg;
    logic                    done_reg;
    logic                    err_reg;

    mode_cfg_t   cfg;
    logic [3:0]  nk_last;
    logic [31:0] key_word [NW];
    logic [31:0] prev_word;
    logic [31:0] sbox_in;
    logic [31:0] sub_word;
    logic [31:0] t_word;
    logic [31:0] key_sel;
    logic [31:0] old_word;
    logic [31:0] w_next;
    logic        advance;
    logic        xfer;
    logic        start_legal;

    assign cfg       = mode_cfg(mode_reg);
    assign nk_last   = cfg.nk - 4'd1;
    assign prev_word = win_reg[0];
    assign xfer      = rk_valid_reg && ks.rk_ready;
    // A pending, unaccepted round key freezes the whole generator
    assign advance   = (state_reg == ST_GEN) && !(rk_valid_reg && !ks.rk_ready);
    assign start_legal = (key_len_e'(ks.key_len) != KEY_RSVD) &&
                         (key_bits(ks.key_len) <= MAX_KEY_BITS);

    // Latched key split into 32-bit words, word 0 from the MSBs
    for (genvar gi = 0; gi < NW; gi++) begin : g_key_word
        assign key_word[gi] = key_reg[MAX_KEY_BITS-1-32*gi -: 32];
    end

    // RotWord is applied only on the rcon step; otherwise SubWord sees w[i-1]
    assign sbox_in = (k_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sbox_in[8*gi +: 8]),
            .out_byte (sub_word[8*gi +: 8])
        );
    end

    // Next schedule word: a key word during the first Nk steps, else the recurrence
    always_comb begin
        t_word = prev_word;
        if (k_reg == 3'd0) begin
            t_word = sub_word ^ {rcon_reg, 24'h000000};
        end else if (cfg.nk == 4'd8 && k_reg == 3'd4) begin
            t_word = sub_word;
        end
        key_sel  = '0;
        old_word = '0;
        for (int j = 0; j < NW; j++) begin
            if (k_reg == 3'(j)) key_sel = key_word[j];
            if (nk_last == 4'(j)) old_word = win_reg[j];
        end
        if (i_reg < {2'b00, cfg.nk}) begin
            w_next = key_sel;
        end else begin
            w_next = old_word ^ t_word;
        end
    end

    // Control FSM: request intake, word/rcon counters, completion pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            key_reg   <= '0;
            mode_reg  <= 2'd0;
            i_reg     <= 6'd0;
            k_reg     <= 3'd0;
            rcon_reg  <= 8'h00;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            err_reg  <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ks.start) begin
                        if (start_legal) begin
                            key_reg   <= ks.key_in;
                            mode_reg  <= ks.key_len;
                            state_reg <= ST_LOAD;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    i_reg     <= 6'd0;
                    k_reg     <= 3'd0;
                    rcon_reg  <= RCON_INIT;
                    state_reg <= ST_GEN;
                end
                ST_GEN: begin
                    if (advance) begin
                        i_reg <= i_reg + 6'd1;
                        k_reg <= (k_reg == nk_last[2:0]) ? 3'd0 : k_reg + 3'd1;
                        if (k_reg == 3'd0 && i_reg >= {2'b00, cfg.nk}) begin
                            rcon_reg <= xtime(rcon_reg);
                        end
                        if (i_reg == cfg.total - 6'd1) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer && rk_last_reg) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Sliding window of the most recent words, newest in slot 0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NW; j++) win_reg[j] <= '0;
        end else if (advance) begin
            win_reg[0] <= w_next;
            for (int j = 1; j < NW; j++) win_reg[j] <= win_reg[j-1];
        end
    end

    // Four-word packing and the round-key output register with handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg      <= '0;
            rk_data_reg  <= '0;
            rk_idx_reg   <= 4'd0;
            rk_valid_reg <= 1'b0;
            rk_last_reg  <= 1'b0;
        end else begin
            if (advance) begin
                acc_reg <= {acc_reg[63:0], w_next};
            end
            if (advance && i_reg[1:0] == 2'b11) begin
                rk_data_reg  <= {acc_reg, w_next};
                rk_idx_reg   <= i_reg[5:2];
                rk_last_reg  <= (i_reg[5:2] == cfg.nr);
                rk_valid_reg <= 1'b1;
            end else if (xfer) begin
                rk_valid_reg <= 1'b0;
            end
        end
    end

    assign ks.busy     = (state_reg != ST_IDLE);
    assign ks.err      = err_reg;
    assign ks.rk_valid = rk_valid_reg;
    assign ks.rk_data  = rk_data_reg;
    assign ks.rk_idx   = rk_idx_reg;
    assign ks.rk_last  = rk_last_reg & rk_valid_reg;
    assign ks.done     = done_reg;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: directed FIPS-197 vectors,
// scoreboard queue filled at request time, monitor checks each accepted key.
module tb_aes_key_schedule;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    aes_key_schedule_if #(.MAX_KEY_BITS(256)) ks();

    aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
        .clk   (clk),
        .reset (reset),
        .ks    (ks)
    );

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
        logic         last;
        logic         chk;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   accepted = 0;
    bit   rand_ready = 1'b0;

    logic [255:0] k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    logic [255:0] k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    logic [127:0] rk192_last = 128'he98ba06f448c773c8ecc720401002202;
    logic [127:0] rk256_last = 128'hfe4890d1e6188d0b046df344706c631e;
    logic [127:0] aes128_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Queue the expected round-key stream for one request
    task automatic expect_seq(input logic [1:0] len);
        exp_t e;
        int   nr;
        nr = (len == 2'd0) ? 10 : (len == 2'd1) ? 12 : 14;
        for (int r = 0; r <= nr; r++) begin
            e.idx  = 4'(r);
            e.last = (r == nr);
            e.chk  = 1'b0;
            e.data = '0;
            if (len == 2'd0) begin
                e.chk = 1'b1; e.data = aes128_rk[r];
            end else if (r == 0) begin
                e.chk = 1'b1; e.data = (len == 2'd1) ? k192[255:128] : k256[255:128];
            end else if (len == 2'd2 && r == 1) begin
                e.chk = 1'b1; e.data = k256[127:0];
            end else if (r == nr) begin
                e.chk = 1'b1; e.data = (len == 2'd1) ? rk192_last : rk256_last;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic start_req(input logic [1:0] len, input logic [255:0] key);
        @(posedge clk); #1;
        ks.start = 1'b1; ks.key_len = len; ks.key_in = key;
        @(posedge clk); #1;
        ks.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (ks.done) break;
            n++;
        end
        checks++;
        if (!ks.done) begin
            errors++;
            $display("FAIL %s_timeout: done=0 required 1 within 500 cycles", name);
        end
        check({name, "_busy_after_done"}, 128'(ks.busy), 128'(0));
        check({name, "_keys_left"}, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"},     128'(ks.busy),     128'(0));
        check({name, "_err"},      128'(ks.err),      128'(0));
        check({name, "_rk_valid"}, 128'(ks.rk_valid), 128'(0));
        check({name, "_rk_data"},  ks.rk_data,        128'(0));
        check({name, "_rk_idx"},   128'(ks.rk_idx),   128'(0));
        check({name, "_rk_last"},  128'(ks.rk_last),  128'(0));
        check({name, "_done"},     128'(ks.done),     128'(0));
    endtask

    // rk_ready driver: held high or randomly low about 30% of cycles
    initial begin
        ks.rk_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ks.rk_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks stall stability and done
    exp_t         mon_e;
    bit           done_exp   = 1'b0;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic [3:0]   prev_idx;
    always @(negedge clk) begin
        if (reset) begin
            done_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (ks.done || done_exp) check("done_pulse", 128'(ks.done), 128'(done_exp));
            done_exp = 1'b0;
            if (prev_stall) begin
                check("stall_valid", 128'(ks.rk_valid), 128'(1));
                check("stall_data",  ks.rk_data, prev_data);
                check("stall_idx",   128'(ks.rk_idx), 128'(prev_idx));
            end
            if (ks.rk_valid && ks.rk_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key: got idx %0d data %h required no transfer",
                             ks.rk_idx, ks.rk_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    accepted++;
                    $display("key idx=%0d data=%h last=%0d", ks.rk_idx, ks.rk_data, ks.rk_last);
                    check("rk_idx",  128'(ks.rk_idx),  128'(mon_e.idx));
                    check("rk_last", 128'(ks.rk_last), 128'(mon_e.last));
                    if (mon_e.chk) check("rk_data", ks.rk_data, mon_e.data);
                    done_exp = mon_e.last;
                end
            end
            prev_stall = ks.rk_valid && !ks.rk_ready;
            prev_data  = ks.rk_data;
            prev_idx   = ks.rk_idx;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int n;
        reset = 1'b1;
        ks.start = 1'b0; ks.key_len = 2'd0; ks.key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // AES-128 with rk_ready high, including first-key latency
        expect_seq(2'd0);
        start_req(2'd0, k128);
        check("busy_after_start", 128'(ks.busy), 128'(1));
        repeat (4) @(posedge clk);
        #1;
        check("rk0_not_early", 128'(ks.rk_valid), 128'(0));
        @(posedge clk); #1;
        check("rk0_latency", 128'(ks.rk_valid), 128'(1));
        check("rk0_data", ks.rk_data, aes128_rk[0]);
        wait_done("aes128");
        $display("txn aes128 complete");

        // AES-192 with a second start while busy
        expect_seq(2'd1);
        start_req(2'd1, k192);
        repeat (10) @(posedge clk);
        start_req(2'd2, k256);
        check("busy_start_no_err", 128'(ks.err), 128'(0));
        wait_done("aes192");
        $display("txn aes192 complete");

        // AES-256
        expect_seq(2'd2);
        start_req(2'd2, k256);
        wait_done("aes256");
        $display("txn aes256 complete");

        // AES-128 with random backpressure
        rand_ready = 1'b1;
        expect_seq(2'd0);
        start_req(2'd0, k128);
        wait_done("aes128_bp");
        rand_ready = 1'b0;
        $display("txn aes128 backpressure complete");

        // Reserved key length is rejected
        start_req(2'd3, k128);
        check("illegal_err",   128'(ks.err),      128'(1));
        check("illegal_busy",  128'(ks.busy),     128'(0));
        check("illegal_valid", 128'(ks.rk_valid), 128'(0));
        @(posedge clk); #1;
        check("illegal_err_pulse", 128'(ks.err), 128'(0));
        repeat (10) @(posedge clk);
        #1;
        check("illegal_idle_busy",  128'(ks.busy),     128'(0));
        check("illegal_idle_valid", 128'(ks.rk_valid), 128'(0));
        $display("txn illegal start complete");

        // Reset after round key 3 of AES-256
        expect_seq(2'd2);
        target = accepted + 4;
        start_req(2'd2, k256);
        n = 0;
        while (accepted < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (accepted < target) begin
            errors++;
            $display("FAIL reset_wait_timeout: accepted %0d required %0d", accepted, target);
        end
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        reset = 1'b0;
        $display("txn reset during aes256 complete");

        // Fresh AES-128 after the reset
        expect_seq(2'd0);
        start_req(2'd0, k128);
        wait_done("aes128_after_reset");
        $display("txn aes128 after reset complete");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Parametrised AES key-expansion engine that replaces the fixed AES-128 expander. It supports AES-128/192/256, selectable per request. It generates the FIPS-197 word sequence w[i] one 32-bit word per cycle from a sliding window of the last Nk words, packs every four words into a 128-bit round key, and streams the round keys to the cipher datapath over a valid/ready handshake with backpressure. It sits between the key-load register and the round-key consumer (cipher core or round-key RAM writer).

## Interface
- MAX_KEY_BITS, 256: largest supported key size (128, 192 or 256). It sizes the word window to MAX_KEY_BITS/32 words. Modes above this are rejected.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- start  in  1  request pulse. Sampled only when busy=0.
- key_len  in  2  key size: 0=128, 1=192, 2=256, 3=reserved.
- key_in  in  MAX_KEY_BITS  cipher key, left-aligned, first key byte in the MSBs. Unused LSBs are ignored.
- busy  out  1  expansion in progress. Reset 0.
- err  out  1  one-cycle pulse on a rejected start. Reset 0.
- rk_valid  out  1  round key available. Reset 0.
- rk_ready  in  1  consumer accepts round key.
- rk_data  out  128  round key, w[4r] in bits 127:96. Reset 0.
- rk_idx  out  4  round number r of rk_data, 0..Nr. Reset 0.
- rk_last  out  1  rk_idx==Nr, qualified by rk_valid. Reset 0.
- done  out  1  one-cycle pulse after the last round key is accepted. Reset 0.

## Operation
- Mode constants:
  - key_len 0: Nk=4, Nr=10, 44 words.
  - key_len 1: Nk=6, Nr=12, 52 words.
  - key_len 2: Nk=8, Nr=14, 60 words.
- States and transitions:
  - IDLE -> LOAD on a legal start.
  - LOAD -> GEN after latching the key, the mode, i=0, rcon=0x01 and k=0 (the i mod Nk counter).
  - GEN -> DRAIN once w[total-1] is written.
  - DRAIN -> IDLE on acceptance of the last round key.
- Word rule in GEN, for i<Nk: w[i] = key word i.
- Word rule in GEN, for i≥Nk, with t = w[i-1]:
  - If k==0: t = SubWord(RotWord(t)) xor {rcon,24'h0}, then rcon = xtime(rcon).
  - Else if Nk==8 and k==4: t = SubWord(t).
  - Then w[i] = w[i-Nk] xor t.
- Window: a shift register of MAX_KEY_BITS/32 words. w[i-Nk] is selected by mode.
- Packing: a 4-word accumulator. On the 4th word, rk_data is loaded, rk_valid is set, and rk_idx = i>>2.
- Backpressure: while rk_valid=1 and rk_ready=0, GEN stalls. i, k, rcon and the window all hold, and rk_data is stable.
- Handshake: transfer occurs when rk_valid and rk_ready are both 1. rk_valid drops on the next edge unless a new key loads at that same edge.
- Illegal start (key_len==3, or size > MAX_KEY_BITS): err pulses, state stays IDLE, no output.
- start while busy=1: ignored, no err.
- Reset in any state: all state and outputs return to reset values at the next edge. Partial round keys are discarded.

## Timing
- start high at edge T0 means busy=1 after T0.
- w[0] is written at T2. w[i] is written at T2+i when there are no stalls.
- Round key r is visible after edge T5+4r with rk_ready held 1: one key every 4 cycles.
- AES-128 with rk_ready=1: last key after T45, done pulses after T46, busy=0 after T46.
- rk_ready is never required before rk_valid. Asserting it with rk_valid=0 has no effect.
- Worst-case S-box path: 4 parallel S-boxes plus the xor chain, all within one cycle.

## Structure
- Package aes_pkg holds:
  - the key_len encoding, Nk/Nr/total-word constants per mode, and the state enum;
  - the xtime function and the rcon initial value.
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4× for SubWord. It is shared with the cipher core.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1. Required response:
  - rk_idx 1 = a0fafe1788542cb123a339392a6c7605;
  - rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1;
  - 11 keys total, done pulse.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_idx 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_idx 14 = fe4890d1e6188d0b046df344706c631e.
- AES-128 with random rk_ready (about 30% low). Required response:
  - same 11 keys in order;
  - rk_data stable while stalled;
  - no duplicates and no drops.
- key_len=3 start -> err pulse, busy=0, no rk_valid. A start pulse during busy -> ignored; the sequence is unchanged.
- Reset asserted after round key 3 of AES-256 -> all outputs 0 next cycle. A fresh AES-128 start then yields the correct round-1 key.
